// File: rtl/hbridge_coil_array_pkg.sv
// Shared drive-state encoding, default widths and the gate decoder.
// Imported by every hbridge_coil_array file.
package hbridge_coil_array_pkg;

    localparam int DEF_NUM_COILS  = 2;
    localparam int DEF_CUR_W      = 13;
    localparam int DEF_STEP       = 1;
    localparam int DEF_DECAY_FAST = 2;

    typedef enum logic [2:0] {
        DRIVE_POS,
        DRIVE_NEG,
        BRAKE,
        COAST,
        ILLEGAL
    } drive_t;

    function automatic drive_t decode_drive(
        input logic h1,
        input logic l1,
        input logic h2,
        input logic l2
    );
        logic [3:0] g;
        drive_t     d;
        g = {h1, l1, h2, l2};
        d = ILLEGAL;
        unique case (1'b1)
            (g == 4'b1001): d = DRIVE_POS;
            (g == 4'b0110): d = DRIVE_NEG;
            (g == 4'b0101): d = BRAKE;
            (g == 4'b0000): d = COAST;
            default:        d = ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hbridge_coil_array_chan.sv
// One coil channel: current integrator, duty counter, comparator, fault.
// Fault flag built only with HBRIDGE_SHOOT_THROUGH_CHECK_EN.
module hbridge_coil_chan
    import hbridge_coil_array_pkg::*;
#(
    parameter int CUR_W      = DEF_CUR_W,
    parameter int STEP       = DEF_STEP,
    parameter int DECAY_FAST = DEF_DECAY_FAST
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             win_max,
    input  logic             high_1,
    input  logic             low_1,
    input  logic             high_2,
    input  logic             low_2,
    input  logic             polarity_invert,
    input  logic             pwm,
    input  logic             fault_clr,
    output logic [CUR_W-1:0] current,
    output logic [CUR_W-2:0] target,
    output logic             cmp,
    output logic             fault
);

    localparam int MW = CUR_W - 1;
    localparam int XW = CUR_W + 2;

    localparam logic signed [XW-1:0] LIM   = XW'((1 << MW) - 1);
    localparam logic signed [XW-1:0] STP_X = XW'(STEP);
    localparam logic signed [XW-1:0] DEC_X = XW'(DECAY_FAST);
    localparam logic signed [XW-1:0] ONE_X = XW'(1);
    localparam logic signed [XW-1:0] ZERO  = '0;

    drive_t                 drv;
    logic signed [XW-1:0]   cur_x;
    logic signed [XW-1:0]   nxt;
    logic [CUR_W-1:0]       cur_q;
    logic [MW-1:0]          tgt_q;
    logic [MW-1:0]          hc_q;
    logic [MW-1:0]          hc_nxt;
    logic [MW-1:0]          mag;
    logic                   cmp_q;

    assign drv   = decode_drive(high_1, low_1, high_2, low_2);
    assign cur_x = XW'($signed(cur_q));

    // next current: apply drive delta or decay, then clamp symmetrically
    always_comb begin
        nxt = cur_x;
        unique case (drv)
            DRIVE_POS: nxt = polarity_invert ? cur_x - STP_X : cur_x + STP_X;
            DRIVE_NEG: nxt = polarity_invert ? cur_x + STP_X : cur_x - STP_X;
            BRAKE: begin
                if (cur_x > ZERO)
                    nxt = cur_x - ONE_X;
                else if (cur_x < ZERO)
                    nxt = cur_x + ONE_X;
                else
                    nxt = ZERO;
            end
            COAST: begin
                if (cur_x > DEC_X)
                    nxt = cur_x - DEC_X;
                else if (cur_x < -DEC_X)
                    nxt = cur_x + DEC_X;
                else
                    nxt = ZERO;
            end
            default: nxt = cur_x;
        endcase
        if (nxt > LIM)
            nxt = LIM;
        else if (nxt < -LIM)
            nxt = -LIM;
    end

    // current magnitude fits MW bits since the most negative code never occurs
    always_comb begin
        mag = cur_q[CUR_W-1] ? MW'(-cur_q) : cur_q[MW-1:0];
    end

    // saturating count of pwm-high cycles, including the current cycle
    always_comb begin
        hc_nxt = hc_q;
        if (pwm && (hc_q != '1))
            hc_nxt = hc_q + MW'(1);
    end

    // integrator register
    always_ff @(posedge clock) begin
        if (!resetn)
            cur_q <= '0;
        else
            cur_q <= nxt[CUR_W-1:0];
    end

    // duty measurement: latch count at window end, then restart
    always_ff @(posedge clock) begin
        if (!resetn) begin
            hc_q  <= '0;
            tgt_q <= '0;
        end else if (win_max) begin
            hc_q  <= '0;
            tgt_q <= hc_nxt;
        end else begin
            hc_q  <= hc_nxt;
        end
    end

    // comparator on previously registered current and target
    always_ff @(posedge clock) begin
        if (!resetn)
            cmp_q <= 1'b1;
        else
            cmp_q <= (mag >= tgt_q);
    end

`ifdef HBRIDGE_SHOOT_THROUGH_CHECK_EN
    logic fault_q;

    // sticky shoot-through flag, a new hit beats a clear
    always_ff @(posedge clock) begin
        if (!resetn)
            fault_q <= 1'b0;
        else if (drv == ILLEGAL)
            fault_q <= 1'b1;
        else if (fault_clr)
            fault_q <= 1'b0;
    end

    assign fault = fault_q;
`else
    logic fault_clr_unused;
    assign fault_clr_unused = fault_clr;
    assign fault = 1'b0;
`endif

    assign current = cur_q;
    assign target  = tgt_q;
    assign cmp     = cmp_q;

endmodule

// File: rtl/hbridge_coil_array.sv
// H-bridge coil array: shared duty window counter plus NUM_COILS channels.
// Optional shoot-through fault flags: HBRIDGE_SHOOT_THROUGH_CHECK_EN.
module hbridge_coil_array
    import hbridge_coil_array_pkg::*;
#(
    parameter int NUM_COILS  = DEF_NUM_COILS,
    parameter int CUR_W      = DEF_CUR_W,
    parameter int STEP       = DEF_STEP,
    parameter int DECAY_FAST = DEF_DECAY_FAST
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic [NUM_COILS-1:0]           high_1,
    input  logic [NUM_COILS-1:0]           low_1,
    input  logic [NUM_COILS-1:0]           high_2,
    input  logic [NUM_COILS-1:0]           low_2,
    input  logic [NUM_COILS-1:0]           polarity_invert,
    input  logic [NUM_COILS-1:0]           pwm,
    input  logic                           fault_clr,
    output logic [NUM_COILS*CUR_W-1:0]     current,
    output logic [NUM_COILS*(CUR_W-1)-1:0] target,
    output logic [NUM_COILS-1:0]           cmp,
    output logic [NUM_COILS-1:0]           fault
);

    localparam int MW = CUR_W - 1;

    logic [MW-1:0] win_q;
    logic          win_max;

    assign win_max = (win_q == '1);

    // free-running duty window, wraps naturally at its maximum
    always_ff @(posedge clock) begin
        if (!resetn)
            win_q <= '0;
        else
            win_q <= win_q + MW'(1);
    end

    for (genvar n = 0; n < NUM_COILS; n++) begin : g_chan
        hbridge_coil_chan #(
            .CUR_W      (CUR_W),
            .STEP       (STEP),
            .DECAY_FAST (DECAY_FAST)
        ) u_chan (
            .clock           (clock),
            .resetn          (resetn),
            .win_max         (win_max),
            .high_1          (high_1[n]),
            .low_1           (low_1[n]),
            .high_2          (high_2[n]),
            .low_2           (low_2[n]),
            .polarity_invert (polarity_invert[n]),
            .pwm             (pwm[n]),
            .fault_clr       (fault_clr),
            .current         (current[n*CUR_W +: CUR_W]),
            .target          (target[n*MW +: MW]),
            .cmp             (cmp[n]),
            .fault           (fault[n])
        );
    end

endmodule

// File: tb/tb_hbridge_coil_array.sv
// Directed scoreboard bench for hbridge_coil_array, 4 channels, CUR_W=13.
// Fault expectations follow HBRIDGE_SHOOT_THROUGH_CHECK_EN.
module tb_hbridge_coil_array;

    localparam int N  = 4;
    localparam int CW = 13;
    localparam int TW = CW - 1;

`ifdef HBRIDGE_SHOOT_THROUGH_CHECK_EN
    localparam int EN = 1;
`else
    localparam int EN = 0;
`endif

    localparam int S_CUR = 0;
    localparam int S_TGT = 1;
    localparam int S_CMP = 2;
    localparam int S_FLT = 3;

    logic            clock;
    logic            resetn;
    logic [N-1:0]    h1, l1, h2, l2;
    logic [N-1:0]    pinv;
    logic [N-1:0]    pwm;
    logic            fault_clr;
    logic [N*CW-1:0] current;
    logic [N*TW-1:0] target;
    logic [N-1:0]    cmp;
    logic [N-1:0]    fault;

    typedef struct {
        string tag;
        int    sel;
        int    ch;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   fails;

    hbridge_coil_array #(
        .NUM_COILS  (N),
        .CUR_W      (CW),
        .STEP       (1),
        .DECAY_FAST (2)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .high_1          (h1),
        .low_1           (l1),
        .high_2          (h2),
        .low_2           (l2),
        .polarity_invert (pinv),
        .pwm             (pwm),
        .fault_clr       (fault_clr),
        .current         (current),
        .target          (target),
        .cmp             (cmp),
        .fault           (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // code: 0 coast, 1 pos, 2 neg, 3 brake, 4 illegal (high_1 & low_1)
    task automatic set_drv(input int ch, input int code);
        h1[ch] = (code == 1) || (code == 4);
        l1[ch] = (code == 2) || (code == 3) || (code == 4);
        h2[ch] = (code == 2);
        l2[ch] = (code == 1) || (code == 3);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_v(input string tag, input int sel,
                            input int ch, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.ch  = ch;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic int obs(input int sel, input int ch);
        int r;
        r = 0;
        case (sel)
            S_CUR:   r = int'($signed(current[ch*CW +: CW]));
            S_TGT:   r = int'(target[ch*TW +: TW]);
            S_CMP:   r = int'(cmp[ch]);
            default: r = int'(fault[ch]);
        endcase
        return r;
    endfunction

    task automatic check_all();
        exp_t e;
        int   o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel, e.ch);
            tests++;
            assert (o === e.val) else begin
                fails++;
                $error("FAIL %s ch%0d: got %0d expected %0d",
                       e.tag, e.ch, o, e.val);
            end
        end
    endtask

    task automatic expect_reset(input string tag);
        for (int c = 0; c < N; c++) begin
            expect_v({tag, "_cur"}, S_CUR, c, 0);
            expect_v({tag, "_tgt"}, S_TGT, c, 0);
            expect_v({tag, "_cmp"}, S_CMP, c, 1);
            expect_v({tag, "_flt"}, S_FLT, c, 0);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        resetn    = 1'b0;
        h1        = '0;
        l1        = '0;
        h2        = '0;
        l2        = '0;
        pinv      = '0;
        pwm       = '0;
        fault_clr = 1'b0;

        expect_reset("rst");
        step(2);
        check_all();

        set_drv(0, 1);
        set_drv(1, 1);
        pinv[1] = 1'b1;
        set_drv(2, 2);
        set_drv(3, 3);
        resetn = 1'b1;
        expect_v("pos100", S_CUR, 0, 100);
        expect_v("inv100", S_CUR, 1, -100);
        expect_v("neg100", S_CUR, 2, -100);
        expect_v("brake0", S_CUR, 3, 0);
        for (int c = 0; c < N; c++)
            expect_v("cmp_t0", S_CMP, c, 1);
        step(100);
        check_all();

        set_drv(0, 4);
        expect_v("ill_hold", S_CUR, 0, 100);
        expect_v("ill_flt", S_FLT, 0, EN);
        expect_v("ill_iso", S_FLT, 1, 0);
        expect_v("ill_nbr", S_CUR, 1, -101);
        step(1);
        check_all();

        fault_clr = 1'b1;
        expect_v("clr_ill_flt", S_FLT, 0, EN);
        expect_v("clr_ill_cur", S_CUR, 0, 100);
        step(1);
        check_all();

        set_drv(0, 0);
        expect_v("clr_flt", S_FLT, 0, 0);
        expect_v("coast1", S_CUR, 0, 98);
        step(1);
        check_all();
        fault_clr = 1'b0;

        set_drv(0, 1);
        set_drv(1, 3);
        expect_v("sat_pos", S_CUR, 0, 4095);
        expect_v("brake_to0", S_CUR, 1, 0);
        expect_v("sat_neg", S_CUR, 2, -4095);
        expect_v("brake_hold", S_CUR, 3, 0);
        step(5000);
        check_all();
        expect_v("sat_stay", S_CUR, 0, 4095);
        step(5);
        check_all();

        set_drv(0, 0);
        set_drv(2, 0);
        set_drv(1, 2);
        set_drv(3, 1);
        pwm[1] = 1'b1;
        expect_v("coast2047", S_CUR, 0, 1);
        expect_v("coastn2047", S_CUR, 2, -1);
        expect_v("invneg", S_CUR, 1, 2047);
        expect_v("pos2047", S_CUR, 3, 2047);
        step(2047);
        check_all();
        expect_v("coast2048", S_CUR, 0, 0);
        expect_v("coastn2048", S_CUR, 2, 0);
        step(1);
        check_all();
        expect_v("coast_stay", S_CUR, 0, 0);
        expect_v("coastn_stay", S_CUR, 2, 0);
        expect_v("invneg2", S_CUR, 1, 2058);
        expect_v("pos2058", S_CUR, 3, 2058);
        step(10);
        check_all();

        resetn = 1'b0;
        expect_reset("midrst");
        step(1);
        check_all();

        for (int c = 0; c < N; c++)
            set_drv(c, 0);
        pinv   = '0;
        resetn = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            pwm[0] = (i < 1024);
            pwm[1] = 1'b1;
            pwm[2] = 1'b0;
            pwm[3] = ((i % 4) == 0);
            if (i == 4095) begin
                for (int c = 0; c < N; c++)
                    expect_v("tgt_early", S_TGT, c, 0);
                check_all();
            end
            step(1);
        end
        expect_v("tgt1024", S_TGT, 0, 1024);
        expect_v("tgt_full", S_TGT, 1, 4095);
        expect_v("tgt_zero", S_TGT, 2, 0);
        expect_v("tgt_q4", S_TGT, 3, 1024);
        check_all();

        pwm = '0;
        set_drv(0, 1);
        set_drv(1, 2);
        set_drv(2, 1);
        set_drv(3, 3);
        expect_v("ramp1023", S_CUR, 0, 1023);
        expect_v("cmp_lo", S_CMP, 0, 0);
        expect_v("cmp_full", S_CMP, 1, 0);
        expect_v("cmp_t0b", S_CMP, 2, 1);
        expect_v("cmp_q4", S_CMP, 3, 0);
        step(1023);
        check_all();
        expect_v("ramp1024", S_CUR, 0, 1024);
        expect_v("cmp_lat", S_CMP, 0, 0);
        step(1);
        check_all();
        expect_v("ramp1025", S_CUR, 0, 1025);
        expect_v("cmp_rise", S_CMP, 0, 1);
        expect_v("ind_neg", S_CUR, 1, -1025);
        expect_v("ind_pos", S_CUR, 2, 1025);
        expect_v("ind_brk", S_CUR, 3, 0);
        step(1);
        check_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
